// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into aligned word accesses,
// with read-modify-write for sub-word stores and sign/zero-extended loads.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_ren,
  output logic        mem_wen,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RSP,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    req_err = (req_size == 2'b11)
            || (req_size == 2'b01 && req_addr[0])
            || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            || (req_addr >= 32'(MEM_BYTES));
    byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          sgn_d   = req_signed;
          lane_d  = req_addr[1:0];
          wdata_d = req_wdata;
          if (req_err) begin
            state_d = S_ERR;
          end else begin
            addr_d = {req_addr[31:2], 2'b00};
            if (req_we && req_size == 2'b10) begin
              wbuf_d  = req_wdata;
              state_d = S_WR;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        if (we_q) begin
          // Merge the new lane(s) into the word just read back.
          wbuf_d = mem_rdata;
          if (size_q == 2'b00) begin
            wbuf_d[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
          end else if (lane_q[1]) begin
            wbuf_d[31:16] = wdata_q[15:0];
          end else begin
            wbuf_d[15:0] = wdata_q[15:0];
          end
          state_d = S_WR;
        end else begin
          unique case (size_q)
            2'b00:   rdata_d = {{24{sgn_q & byte_sel[7]}}, byte_sel};
            2'b01:   rdata_d = {{16{sgn_q & half_sel[15]}}, half_sel};
            default: rdata_d = mem_rdata;
          endcase
          state_d = S_RSP;
        end
      end
      S_WR:    state_d = S_RSP;
      S_RSP:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      lane_q  <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE) && !reset;
  assign mem_ren    = (state_q == S_RD);
  assign mem_wen    = (state_q == S_WR);
  assign resp_valid = (state_q == S_RSP) || (state_q == S_ERR);
  assign resp_err   = (state_q == S_ERR);
  assign resp_rdata = rdata_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wbuf_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: attached 512-byte memory plus a byte-array
// reference model that predicts error, latency, strobes and data.
module tb_load_store_unit;

  logic        clk, reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ren, mem_wen;

  load_store_unit #(.MEM_BYTES(512)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [128];
  always @(posedge clk) begin
    if (!reset) begin
      if (mem_wen) mem[mem_addr[8:2]] <= mem_wdata;
      if (mem_ren) mem_rdata <= mem[mem_addr[8:2]];
    end
  end

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [7:0]  ref_bytes [512];
  logic        exp_err;
  int          exp_lat, exp_ren, exp_wen;
  logic [31:0] exp_rdata, exp_word;

  // Observations from one request
  int          obs_lat, obs_ren, obs_wen, obs_both, obs_busy, obs_wait;
  logic        obs_err, obs_timeout;
  logic [31:0] obs_rdata, obs_waddr, obs_wdata, obs_raddr;

  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned nb, base;
    logic [31:0] v;
    nb = 1 << size;
    exp_err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
              (size == 2'd2 && addr[1:0] != 2'd0) || (addr >= 32'd512);
    exp_ren = 0;
    exp_wen = 0;
    if (exp_err) begin
      exp_lat = 1;
    end else if (we) begin
      for (int i = 0; i < int'(nb); i++) ref_bytes[int'(addr) + i] = wdata[8*i +: 8];
      base = addr & ~32'd3;
      exp_word = {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
      exp_wen = 1;
      exp_ren = (size == 2'd2) ? 0 : 1;
      exp_lat = (size == 2'd2) ? 2 : 4;
    end else begin
      v = 0;
      for (int i = 0; i < int'(nb); i++) v = v | (32'(ref_bytes[int'(addr) + i]) << (8*i));
      if (sgn && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
      exp_rdata = v;
      exp_ren = 1;
      exp_lat = 3;
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    obs_wait = 0; obs_ren = 0; obs_wen = 0; obs_both = 0; obs_busy = 0;
    obs_timeout = 1'b0; obs_err = 1'bx; obs_rdata = 'x;
    obs_waddr = 'x; obs_wdata = 'x; obs_raddr = 'x;
    while (!req_ready && obs_wait < 50) begin
      @(posedge clk); #1;
      obs_wait++;
    end
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    obs_lat = 1;
    forever begin
      if (mem_ren) begin obs_ren++; obs_raddr = mem_addr; end
      if (mem_wen) begin obs_wen++; obs_waddr = mem_addr; obs_wdata = mem_wdata; end
      if (mem_ren && mem_wen) obs_both++;
      if (req_ready) obs_busy++;
      if (resp_valid) begin
        obs_err = resp_err;
        obs_rdata = resp_rdata;
        break;
      end
      if (obs_lat >= 12) begin obs_timeout = 1'b1; break; end
      @(posedge clk); #1;
      obs_lat++;
    end
    total++;
    if (obs_timeout) begin
      bad++;
      $display("FAIL resp_timeout: no resp_valid within %0d cycles, required one", obs_lat);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_we = 0; req_size = 0; req_signed = 0;
    req_addr = 0; req_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    total++;
    if ({resp_valid, resp_err, mem_ren, mem_wen} !== 4'b0) begin
      bad++; $display("FAIL reset_strobes: got %b want 0000", {resp_valid, resp_err, mem_ren, mem_wen});
    end
    total++;
    if ({resp_rdata, mem_addr, mem_wdata} !== 96'd0) begin
      bad++; $display("FAIL reset_data: rdata=%h addr=%h wdata=%h want all 0", resp_rdata, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    exp_rdata = 0;
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_word;
    model(1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
    do_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
    total++;
    if (obs_lat !== 2) begin bad++; $display("FAIL word_st_lat: got %0d want 2", obs_lat); end
    total++;
    if (obs_wen !== 1 || obs_ren !== 0) begin bad++; $display("FAIL word_st_strobes: wen=%0d ren=%0d want 1/0", obs_wen, obs_ren); end
    total++;
    if (obs_waddr !== 32'h10 || obs_wdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL word_st_bus: addr=%h data=%h want 00000010/deadbeef", obs_waddr, obs_wdata);
    end
    model(0, 2'd2, 0, 32'h10, 0);
    do_req(0, 2'd2, 0, 32'h10, 0, 0);
    total++;
    if (obs_lat !== 3) begin bad++; $display("FAIL word_ld_lat: got %0d want 3", obs_lat); end
    total++;
    if (obs_rdata !== 32'hDEADBEEF || obs_err !== 1'b0) begin
      bad++; $display("FAIL word_ld_data: got %h err=%b want deadbeef err=0", obs_rdata, obs_err);
    end
  endtask

  task automatic test_byte;
    model(1, 2'd2, 0, 32'h10, 32'h11223344);
    do_req(1, 2'd2, 0, 32'h10, 32'h11223344, 0);
    model(1, 2'd0, 0, 32'h13, 32'h123456A5);
    do_req(1, 2'd0, 0, 32'h13, 32'h123456A5, 0);
    total++;
    if (obs_lat !== 4 || obs_ren !== 1 || obs_wen !== 1) begin
      bad++; $display("FAIL byte_st_seq: lat=%0d ren=%0d wen=%0d want 4/1/1", obs_lat, obs_ren, obs_wen);
    end
    total++;
    if (obs_raddr !== 32'h10 || obs_waddr !== 32'h10 || obs_wdata !== 32'hA5223344) begin
      bad++; $display("FAIL byte_st_bus: raddr=%h waddr=%h wdata=%h want 10/10/a5223344", obs_raddr, obs_waddr, obs_wdata);
    end
    model(0, 2'd0, 1, 32'h13, 0);
    do_req(0, 2'd0, 1, 32'h13, 0, 0);
    total++;
    if (obs_rdata !== 32'hFFFFFFA5) begin bad++; $display("FAIL byte_ld_signed: got %h want ffffffa5", obs_rdata); end
    model(0, 2'd0, 0, 32'h13, 0);
    do_req(0, 2'd0, 0, 32'h13, 0, 0);
    total++;
    if (obs_rdata !== 32'h000000A5) begin bad++; $display("FAIL byte_ld_unsigned: got %h want 000000a5", obs_rdata); end
  endtask

  task automatic test_half;
    model(1, 2'd1, 0, 32'h12, 32'hFFFF8001);
    do_req(1, 2'd1, 0, 32'h12, 32'hFFFF8001, 0);
    total++;
    if (obs_wdata !== 32'h80013344) begin bad++; $display("FAIL half_st_word: got %h want 80013344", obs_wdata); end
    model(0, 2'd2, 0, 32'h10, 0);
    do_req(0, 2'd2, 0, 32'h10, 0, 0);
    total++;
    if (obs_rdata !== 32'h80013344) begin bad++; $display("FAIL half_st_readback: got %h want 80013344", obs_rdata); end
    model(0, 2'd1, 1, 32'h12, 0);
    do_req(0, 2'd1, 1, 32'h12, 0, 0);
    total++;
    if (obs_rdata !== 32'hFFFF8001) begin bad++; $display("FAIL half_ld_signed: got %h want ffff8001", obs_rdata); end
    model(0, 2'd1, 0, 32'h10, 0);
    do_req(0, 2'd1, 0, 32'h10, 0, 0);
    total++;
    if (obs_rdata !== 32'h00003344) begin bad++; $display("FAIL half_ld_unsigned: got %h want 00003344", obs_rdata); end
  endtask

  task automatic test_errors;
    logic [1:0]  sz [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1};
    logic [31:0] ad [6] = '{32'h11, 32'h12, 32'h10, 32'h200, 32'hFFFFFFF0, 32'h203};
    for (int i = 0; i < 6; i++) begin
      model(i[0], sz[i], 1, ad[i], 32'h5A5A5A5A);
      do_req(i[0], sz[i], 1, ad[i], 32'h5A5A5A5A, 0);
      total++;
      if (obs_err !== 1'b1 || obs_lat !== 1) begin
        bad++; $display("FAIL err_resp[%0d]: err=%b lat=%0d want 1/1", i, obs_err, obs_lat);
      end
      total++;
      if (obs_ren !== 0 || obs_wen !== 0 || obs_rdata !== exp_rdata) begin
        bad++; $display("FAIL err_side[%0d]: ren=%0d wen=%0d rdata=%h want 0/0/%h", i, obs_ren, obs_wen, obs_rdata, exp_rdata);
      end
    end
  endtask

  task automatic test_reset_mid;
    int saw_resp, saw_wen;
    model(1, 2'd2, 0, 32'h20, 32'hCAFEF00D);
    do_req(1, 2'd2, 0, 32'h20, 32'hCAFEF00D, 0);
    req_we = 1; req_size = 2'd0; req_signed = 0; req_addr = 32'h21; req_wdata = 32'h77;
    req_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++;
    if (mem_ren !== 1'b1) begin bad++; $display("FAIL mid_reset_rd: mem_ren=%b want 1", mem_ren); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_rdata = 0;
    saw_resp = 0; saw_wen = 0;
    for (int c = 0; c < 6; c++) begin
      if (resp_valid) saw_resp++;
      if (mem_wen) saw_wen++;
      @(posedge clk); #1;
    end
    total++;
    if (saw_resp !== 0 || saw_wen !== 0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset_quiet: resp=%0d wen=%0d ready=%b want 0/0/1", saw_resp, saw_wen, req_ready);
    end
    model(0, 2'd2, 0, 32'h20, 0);
    do_req(0, 2'd2, 0, 32'h20, 0, 0);
    total++;
    if (obs_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL mid_reset_word: got %h want cafef00d", obs_rdata); end
  endtask

  task automatic test_random;
    logic we, sgn;
    logic [1:0] size;
    logic [31:0] addr, wd;
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom);
      sgn = 1'($urandom);
      size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = 32'($urandom_range(0, 130)) * 4;
      if ($urandom_range(0, 4) == 0 || size == 2'd0) addr = addr + 32'($urandom_range(0, 3));
      else if (size == 2'd1) addr = addr + 32'($urandom_range(0, 1)) * 2;
      wd = $urandom;
      model(we, size, sgn, addr, wd);
      do_req(we, size, sgn, addr, wd, 0);
      total++;
      if (obs_err !== exp_err || obs_lat !== exp_lat || obs_rdata !== exp_rdata) begin
        bad++; $display("FAIL rnd_resp[%0d]: err=%b lat=%0d rdata=%h want %b/%0d/%h", n, obs_err, obs_lat, obs_rdata, exp_err, exp_lat, exp_rdata);
      end
      total++;
      if (obs_ren !== exp_ren || obs_wen !== exp_wen || obs_both !== 0 || obs_busy !== 0 ||
          (exp_wen == 1 && (obs_wdata !== exp_word || obs_waddr !== (addr & ~32'd3)))) begin
        bad++; $display("FAIL rnd_mem[%0d]: ren=%0d wen=%0d both=%0d busy=%0d wdata=%h want %0d/%0d/0/0/%h",
                        n, obs_ren, obs_wen, obs_both, obs_busy, obs_wdata, exp_ren, exp_wen, exp_word);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic we;
    logic [1:0] size;
    logic [31:0] addr, wd;
    for (int n = 0; n < 16; n++) begin
      we = n[0] ? 1'b0 : 1'b1;
      size = 2'($urandom_range(0, 2));
      addr = 32'h40 + 32'($urandom_range(0, 3)) * 4;
      if (size == 2'd0) addr = addr + 32'($urandom_range(0, 3));
      if (size == 2'd1) addr = addr + 32'($urandom_range(0, 1)) * 2;
      wd = $urandom;
      model(we, size, n[1], addr, wd);
      do_req(we, size, n[1], addr, wd, 1);
      total++;
      if ((n > 0 && obs_wait !== 1) || obs_lat !== exp_lat || obs_rdata !== exp_rdata ||
          obs_both !== 0 || obs_busy !== 0) begin
        bad++; $display("FAIL b2b[%0d]: wait=%0d lat=%0d rdata=%h both=%0d busy=%0d want 1/%0d/%h/0/0",
                        n, obs_wait, obs_lat, obs_rdata, obs_both, obs_busy, exp_lat, exp_rdata);
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    for (int w = 0; w < 128; w++) begin
      mem[w] = $urandom;
      for (int b = 0; b < 4; b++) ref_bytes[w*4 + b] = mem[w][8*b +: 8];
    end
    exp_rdata = 0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
